ring_addr_gen: RTL

Parametrised ring-buffer address generator for the SDRAM sample store between the AD capture path and the filter read-out path. It keeps independent write and read word pointers over a configurable region [BASE, BASE+DEPTH) and tracks fill level. read_en is gated by a programmable fill threshold with hysteresis; this replaces the fixed first-block gating. Full/empty protection is selectable: writes are dropped when full, or the oldest data is overwritten.

---
 rtl/sdram_ring_pkg.sv | 14 +
 rtl/ring_addr_gen_if.sv | 32 +++
 rtl/ring_ptr.sv | 44 ++++
 rtl/ring_addr_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/sdram_ring_pkg.sv
// Shared SDRAM ring-buffer constants: address width, AD sample region, level sizing.
package sdram_ring_pkg;

    localparam int unsigned SDRAM_ADDR_W   = 25;
    localparam int unsigned AD_RING_BASE   = 0;
    localparam int unsigned AD_RING_DEPTH  = 524288;
    localparam int unsigned AD_RING_THRESH = AD_RING_DEPTH / 2;

    // Bits needed to hold a fill level of 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_addr_gen_if.sv
// Request/status bundle between the ring address generator and its user.
interface ring_addr_gen_if
    import sdram_ring_pkg::*;
#(
    parameter int unsigned ADDR_W = SDRAM_ADDR_W
);
    logic              clr;
    logic              wr_addr_up;
    logic              rd_addr_up;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   level;
    logic              read_en;
    logic              full;
    logic              empty;
    logic              wr_wrap;
    logic              rd_wrap;
    logic              overrun;
    logic              underrun;

    modport master (
        output clr, wr_addr_up, rd_addr_up,
        input  wr_addr, rd_addr, level, read_en, full, empty,
        input  wr_wrap, rd_wrap, overrun, underrun
    );

    modport slave (
        input  clr, wr_addr_up, rd_addr_up,
        output wr_addr, rd_addr, level, read_en, full, empty,
        output wr_wrap, rd_wrap, overrun, underrun
    );
endinterface

// File: rtl/ring_ptr.sv
// Wrapping word pointer over [BASE, BASE+DEPTH) with a one-cycle wrap pulse.
module ring_ptr
    import sdram_ring_pkg::*;
#(
    parameter int unsigned ADDR_W = SDRAM_ADDR_W,
    parameter int unsigned BASE   = AD_RING_BASE,
    parameter int unsigned DEPTH  = AD_RING_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap
);
    localparam logic [ADDR_W-1:0] PtrBase = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(BASE + DEPTH - 1);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= PtrBase;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_ptr  <= PtrBase;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (adv) begin
                if (r_ptr == PtrLast) begin
                    r_ptr  <= PtrBase;
                    r_wrap <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
            end
        end
    end

    assign ptr  = r_ptr;
    assign wrap = r_wrap;
endmodule

// File: rtl/ring_addr_gen.sv
// Ring-buffer address generator: write/read pointers, fill level, thresholded read_en.
module ring_addr_gen
    import sdram_ring_pkg::*;
#(
    parameter int unsigned ADDR_W    = SDRAM_ADDR_W,
    parameter int unsigned BASE      = AD_RING_BASE,
    parameter int unsigned DEPTH     = AD_RING_DEPTH,
    parameter int unsigned RD_THRESH = AD_RING_THRESH,
    parameter bit          OVERWRITE = 1'b0
) (
    input logic             clk,
    input logic             reset,
    ring_addr_gen_if.slave  bus
);
    localparam int unsigned    LvlW    = level_w(DEPTH);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
    localparam logic [LvlW-1:0] LvlThr  = LvlW'(RD_THRESH);

    logic [LvlW-1:0]   r_level;
    logic              r_read_en, r_full, r_empty, r_overrun, r_underrun;

    logic [LvlW-1:0]   w_level_n;
    logic              w_read_en_n;
    logic              w_rd_acc, w_wr_acc, w_full_blk, w_ovw, w_drop, w_rd_adv;
    logic [ADDR_W-1:0] w_wr_ptr, w_rd_ptr;
    logic              w_wr_wrap, w_rd_wrap;

    always_comb begin
        w_rd_acc   = bus.rd_addr_up && !r_empty;
        // Full blocks a write unless a read frees a slot in the same cycle.
        w_full_blk = r_full && !w_rd_acc;
        w_ovw      = bus.wr_addr_up && w_full_blk && OVERWRITE;
        w_drop     = bus.wr_addr_up && w_full_blk && !OVERWRITE;
        w_wr_acc   = bus.wr_addr_up && !w_drop;
        w_rd_adv   = w_rd_acc || w_ovw;

        w_level_n = r_level;
        if (w_wr_acc && !w_rd_acc && !w_ovw) begin
            w_level_n = r_level + LvlW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_n = r_level - LvlW'(1);
        end

        w_read_en_n = r_read_en;
        if (w_level_n == '0) begin
            w_read_en_n = 1'b0;
        end else if (w_level_n >= LvlThr) begin
            w_read_en_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level    <= '0;
            r_read_en  <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (bus.clr) begin
            r_level    <= '0;
            r_read_en  <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_level    <= w_level_n;
            r_read_en  <= w_read_en_n;
            r_full     <= (w_level_n == LvlFull);
            r_empty    <= (w_level_n == '0);
            r_overrun  <= r_overrun || w_drop || w_ovw;
            r_underrun <= r_underrun || (bus.rd_addr_up && r_empty);
        end
    end

    ring_ptr #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .DEPTH  (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .adv   (w_wr_acc),
        .ptr   (w_wr_ptr),
        .wrap  (w_wr_wrap)
    );

    ring_ptr #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .DEPTH  (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .adv   (w_rd_adv),
        .ptr   (w_rd_ptr),
        .wrap  (w_rd_wrap)
    );

    assign bus.wr_addr  = w_wr_ptr;
    assign bus.rd_addr  = w_rd_ptr;
    assign bus.wr_wrap  = w_wr_wrap;
    assign bus.rd_wrap  = w_rd_wrap;
    assign bus.level    = (ADDR_W + 1)'(r_level);
    assign bus.read_en  = r_read_en;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.overrun  = r_overrun;
    assign bus.underrun = r_underrun;
endmodule
